// File: rtl/rob_nway_if.sv
// rtl/rob_nway_if.sv - dispatch, completion, retire and squash bundle of the N-way reorder buffer
interface rob_nway_if #(
  parameter int DEPTH  = 32,
  parameter int N      = 3,
  parameter int C      = 2,
  parameter int DATA_W = 32
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(N + 1);

  logic [N-1:0][DATA_W-1:0] rob_inputs;
  logic [NW-1:0]            rob_inputs_valid;
  logic [NW-1:0]            rob_spots;
  logic [IW-1:0]            rob_tail;
  logic [C-1:0]             cmpl_valid;
  logic [C-1:0][IW-1:0]     cmpl_idx;
  logic [C-1:0]             cmpl_exc;
  logic [N-1:0][DATA_W-1:0] rob_outputs;
  logic [NW-1:0]            rob_outputs_valid;
  logic [NW-1:0]            num_retiring;
  logic                     tail_restore_valid;
  logic [IW-1:0]            tail_restore;
  logic [CW-1:0]            rob_count;
  logic                     rob_flush;

  // Pipeline side: dispatch, writeback network and retire stage
  modport master (
    output rob_inputs, rob_inputs_valid, cmpl_valid, cmpl_idx, cmpl_exc,
           num_retiring, tail_restore_valid, tail_restore,
    input  rob_spots, rob_tail, rob_outputs, rob_outputs_valid, rob_count, rob_flush
  );

  // Reorder buffer side
  modport slave (
    input  rob_inputs, rob_inputs_valid, cmpl_valid, cmpl_idx, cmpl_exc,
           num_retiring, tail_restore_valid, tail_restore,
    output rob_spots, rob_tail, rob_outputs, rob_outputs_valid, rob_count, rob_flush
  );
endinterface

// File: rtl/rob_nway.sv
// rtl/rob_nway.sv - N-way reorder buffer with C completion ports and branch squash (optional ROB_EXCEPTION_EN)
module rob_nway #(
  parameter int DEPTH  = 32,
  parameter int N      = 3,
  parameter int C      = 2,
  parameter int DATA_W = 32
) (
  input logic       clock,
  input logic       reset,
  rob_nway_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(N + 1);

  logic [DEPTH-1:0]  valid_q, valid_n;
  logic [DEPTH-1:0]  done_q, done_n;
  logic [DATA_W-1:0] payload_q [DEPTH];
  logic [IW-1:0]     head_q, head_n, tail_q, tail_n;
  logic [CW-1:0]     count_q, count_n;
`ifdef ROB_EXCEPTION_EN
  logic [DEPTH-1:0]  exc_q, exc_n;
  logic              flush_q;
  logic [IW-1:0]     last_ret;
`else
  logic              unused_exc;
`endif

  logic [IW-1:0] head_plus [N];
  logic [IW-1:0] tail_plus [N];
  logic [CW-1:0] free_slots;
  logic [NW-1:0] spots;
  logic [NW-1:0] out_valid;
  logic          scan_run;
  logic [NW-1:0] disp_k;
  logic [NW-1:0] ret_r;
  logic          exc_retire;
  logic [IW-1:0] keep_span;
  logic [IW-1:0] rel;
  logic [IW-1:0] restore_dist;

  // Slot addresses relative to head and tail, wrapping mod DEPTH
  always_comb begin
    for (int i = 0; i < N; i++) begin
      head_plus[i] = head_q + IW'(i);
      tail_plus[i] = tail_q + IW'(i);
    end
  end

  // Free space is taken from the registered count only, so retire this cycle never feeds dispatch
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    spots      = (free_slots < CW'(N)) ? NW'(free_slots) : NW'(N);
  end

  // Contiguous run of completed entries from head; an excepting entry closes the run
  always_comb begin
    out_valid = '0;
    scan_run  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (scan_run && valid_q[head_plus[i]] && done_q[head_plus[i]]) begin
        out_valid = NW'(i + 1);
`ifdef ROB_EXCEPTION_EN
        if (exc_q[head_plus[i]]) scan_run = 1'b0;
`endif
      end else begin
        scan_run = 1'b0;
      end
    end
  end

  // Accepted dispatch and retire amounts, excess requests clamped
  always_comb begin
    disp_k = (bus.rob_inputs_valid < spots) ? bus.rob_inputs_valid : spots;
    ret_r  = (bus.num_retiring < out_valid) ? bus.num_retiring : out_valid;
  end

  // Retiring the excepting entry wipes the whole buffer
`ifdef ROB_EXCEPTION_EN
  always_comb begin
    last_ret   = head_q + IW'(ret_r) - IW'(1);
    exc_retire = (ret_r != '0) && exc_q[last_ret];
  end
`else
  assign exc_retire = 1'b0;
  assign unused_exc = ^bus.cmpl_exc;
`endif

  // Next state: completions, then retire, then either exception wipe, squash or dispatch
  always_comb begin
    valid_n      = valid_q;
    done_n       = done_q;
`ifdef ROB_EXCEPTION_EN
    exc_n        = exc_q;
`endif
    head_n       = head_q + IW'(ret_r);
    tail_n       = tail_q;
    count_n      = count_q;
    rel          = '0;
    keep_span    = tail_q - bus.tail_restore - IW'(1);
    restore_dist = bus.tail_restore - head_q;

    for (int c = 0; c < C; c++) begin
      if (bus.cmpl_valid[c] && valid_q[bus.cmpl_idx[c]]) begin
        done_n[bus.cmpl_idx[c]] = 1'b1;
`ifdef ROB_EXCEPTION_EN
        if (bus.cmpl_exc[c]) exc_n[bus.cmpl_idx[c]] = 1'b1;
`endif
      end
    end

    for (int i = 0; i < N; i++) begin
      if (NW'(i) < ret_r) begin
        valid_n[head_plus[i]] = 1'b0;
        done_n[head_plus[i]]  = 1'b0;
`ifdef ROB_EXCEPTION_EN
        exc_n[head_plus[i]]   = 1'b0;
`endif
      end
    end

    if (exc_retire) begin
      valid_n = '0;
      done_n  = '0;
`ifdef ROB_EXCEPTION_EN
      exc_n   = '0;
`endif
      tail_n  = head_n;
      count_n = '0;
    end else if (bus.tail_restore_valid) begin
      // Entries strictly younger than the kept branch, up to the old tail, are discarded
      for (int j = 0; j < DEPTH; j++) begin
        rel = IW'(j) - bus.tail_restore - IW'(1);
        if (rel < keep_span) begin
          valid_n[j] = 1'b0;
          done_n[j]  = 1'b0;
`ifdef ROB_EXCEPTION_EN
          exc_n[j]   = 1'b0;
`endif
        end
      end
      tail_n  = bus.tail_restore + IW'(1);
      count_n = CW'(restore_dist) + CW'(1) - CW'(ret_r);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (NW'(i) < disp_k) begin
          valid_n[tail_plus[i]] = 1'b1;
          done_n[tail_plus[i]]  = 1'b0;
`ifdef ROB_EXCEPTION_EN
          exc_n[tail_plus[i]]   = 1'b0;
`endif
        end
      end
      tail_n  = tail_q + IW'(disp_k);
      count_n = count_q + CW'(disp_k) - CW'(ret_r);
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
`ifdef ROB_EXCEPTION_EN
      exc_q   <= '0;
      flush_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_n;
      done_q  <= done_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
`ifdef ROB_EXCEPTION_EN
      exc_q   <= exc_n;
      flush_q <= exc_retire;
`endif
    end
  end

  // Payload storage, written only for accepted dispatch slots
  always_ff @(posedge clock) begin
    if (reset && !exc_retire && !bus.tail_restore_valid) begin
      for (int i = 0; i < N; i++) begin
        if (NW'(i) < disp_k) payload_q[tail_plus[i]] <= bus.rob_inputs[i];
      end
    end
  end

  // Outputs depend on registered state only
  always_comb begin
    for (int i = 0; i < N; i++) bus.rob_outputs[i] = payload_q[head_plus[i]];
    bus.rob_spots         = spots;
    bus.rob_tail          = tail_q;
    bus.rob_outputs_valid = out_valid;
    bus.rob_count         = count_q;
`ifdef ROB_EXCEPTION_EN
    bus.rob_flush         = flush_q;
`else
    bus.rob_flush         = 1'b0;
`endif
  end
endmodule

// File: tb/tb_rob_nway.sv
// tb/tb_rob_nway.sv - directed self-checking bench for rob_nway (DEPTH=8, N=2, C=2)
module tb_rob_nway;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  rob_nway_if #(.DEPTH(8), .N(2), .C(2), .DATA_W(32)) bus ();

  rob_nway #(.DEPTH(8), .N(2), .C(2), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  task automatic idle();
    bus.rob_inputs         = '0;
    bus.rob_inputs_valid   = '0;
    bus.cmpl_valid         = '0;
    bus.cmpl_idx           = '0;
    bus.cmpl_exc           = '0;
    bus.num_retiring       = '0;
    bus.tail_restore_valid = 1'b0;
    bus.tail_restore       = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_dispatch(input int k, input logic [31:0] base);
    bus.rob_inputs_valid = 2'(k);
    bus.rob_inputs[0]    = base;
    bus.rob_inputs[1]    = base + 32'd1;
  endtask

  task automatic set_cmpl(input logic v0, input int i0, input logic e0,
                          input logic v1, input int i1, input logic e1);
    bus.cmpl_valid  = {v1, v0};
    bus.cmpl_idx[0] = 3'(i0);
    bus.cmpl_idx[1] = 3'(i1);
    bus.cmpl_exc    = {e1, e0};
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    set_dispatch(2, 32'h50);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++; if (bus.rob_spots !== 2'd2) begin fails++; $display("FAIL reset_spots: got %0d want 2", bus.rob_spots); end
    tests++; if (bus.rob_tail !== 3'd0) begin fails++; $display("FAIL reset_tail: got %0d want 0", bus.rob_tail); end
    tests++; if (bus.rob_outputs_valid !== 2'd0) begin fails++; $display("FAIL reset_ov: got %0d want 0", bus.rob_outputs_valid); end
    tests++; if (bus.rob_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.rob_count); end
    tests++; if (bus.rob_flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %0d want 0", bus.rob_flush); end
  endtask

  task automatic test_in_order_retire();
    do_reset();
    set_dispatch(2, 32'h10);
    tick();
    tests++; if (bus.rob_count !== 4'd2) begin fails++; $display("FAIL basic_count: got %0d want 2", bus.rob_count); end
    tests++; if (bus.rob_tail !== 3'd2) begin fails++; $display("FAIL basic_tail: got %0d want 2", bus.rob_tail); end
    set_cmpl(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd0) begin fails++; $display("FAIL basic_ov_gap: got %0d want 0", bus.rob_outputs_valid); end
    set_cmpl(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd2) begin fails++; $display("FAIL basic_ov_full: got %0d want 2", bus.rob_outputs_valid); end
    tests++; if (bus.rob_outputs[0] !== 32'h10) begin fails++; $display("FAIL basic_out0: got %h want 10", bus.rob_outputs[0]); end
    tests++; if (bus.rob_outputs[1] !== 32'h11) begin fails++; $display("FAIL basic_out1: got %h want 11", bus.rob_outputs[1]); end
    bus.num_retiring = 2'd2;
    tick();
    tests++; if (bus.rob_count !== 4'd0) begin fails++; $display("FAIL basic_ret_count: got %0d want 0", bus.rob_count); end
    tests++; if (bus.rob_spots !== 2'd2) begin fails++; $display("FAIL basic_ret_spots: got %0d want 2", bus.rob_spots); end
    tests++; if (bus.rob_outputs_valid !== 2'd0) begin fails++; $display("FAIL basic_ret_ov: got %0d want 0", bus.rob_outputs_valid); end
  endtask

  task automatic test_full_and_wrap();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_dispatch(2, 32'h100 + 32'(2 * c));
      tick();
    end
    tests++; if (bus.rob_count !== 4'd8) begin fails++; $display("FAIL full_count: got %0d want 8", bus.rob_count); end
    tests++; if (bus.rob_spots !== 2'd0) begin fails++; $display("FAIL full_spots: got %0d want 0", bus.rob_spots); end
    set_dispatch(2, 32'hDEAD);
    tick();
    tests++; if (bus.rob_count !== 4'd8) begin fails++; $display("FAIL full_drop_count: got %0d want 8", bus.rob_count); end
    tests++; if (bus.rob_tail !== 3'd0) begin fails++; $display("FAIL full_drop_tail: got %0d want 0", bus.rob_tail); end
    set_cmpl(1'b1, 0, 1'b0, 1'b1, 1, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd2) begin fails++; $display("FAIL wrap_ov: got %0d want 2", bus.rob_outputs_valid); end
    // Retire frees space only from the next cycle, so this dispatch finds no spots
    bus.num_retiring = 2'd2;
    set_dispatch(2, 32'hBEEF);
    tick();
    tests++; if (bus.rob_count !== 4'd6) begin fails++; $display("FAIL wrap_ret_count: got %0d want 6", bus.rob_count); end
    tests++; if (bus.rob_tail !== 3'd0) begin fails++; $display("FAIL wrap_ret_tail: got %0d want 0", bus.rob_tail); end
    tests++; if (bus.rob_spots !== 2'd2) begin fails++; $display("FAIL wrap_ret_spots: got %0d want 2", bus.rob_spots); end
    tests++; if (bus.rob_outputs[0] !== 32'h102) begin fails++; $display("FAIL wrap_head_out: got %h want 102", bus.rob_outputs[0]); end
    set_dispatch(2, 32'h200);
    tick();
    tests++; if (bus.rob_count !== 4'd8) begin fails++; $display("FAIL wrap_refill_count: got %0d want 8", bus.rob_count); end
    tests++; if (bus.rob_tail !== 3'd2) begin fails++; $display("FAIL wrap_refill_tail: got %0d want 2", bus.rob_tail); end
    set_cmpl(1'b1, 0, 1'b0, 1'b1, 2, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd1) begin fails++; $display("FAIL wrap_ov_after: got %0d want 1", bus.rob_outputs_valid); end
  endtask

  task automatic test_squash();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_dispatch(2, 32'h300 + 32'(2 * c));
      tick();
    end
    tests++; if (bus.rob_count !== 4'd6) begin fails++; $display("FAIL sq_pre_count: got %0d want 6", bus.rob_count); end
    bus.tail_restore_valid = 1'b1;
    bus.tail_restore       = 3'd2;
    set_dispatch(2, 32'hBAD0);
    tick();
    tests++; if (bus.rob_count !== 4'd3) begin fails++; $display("FAIL sq_count: got %0d want 3", bus.rob_count); end
    tests++; if (bus.rob_tail !== 3'd3) begin fails++; $display("FAIL sq_tail: got %0d want 3", bus.rob_tail); end
    set_cmpl(1'b1, 0, 1'b0, 1'b1, 4, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd1) begin fails++; $display("FAIL sq_ov0: got %0d want 1", bus.rob_outputs_valid); end
    set_dispatch(2, 32'h400);
    tick();
    tests++; if (bus.rob_count !== 4'd5) begin fails++; $display("FAIL sq_redisp_count: got %0d want 5", bus.rob_count); end
    set_cmpl(1'b1, 1, 1'b0, 1'b1, 2, 1'b0);
    tick();
    bus.num_retiring = 2'd2;
    tick();
    bus.num_retiring = 2'd1;
    tick();
    tests++; if (bus.rob_count !== 4'd2) begin fails++; $display("FAIL sq_ret_count: got %0d want 2", bus.rob_count); end
    tests++; if (bus.rob_outputs[0] !== 32'h400) begin fails++; $display("FAIL sq_head_out: got %h want 400", bus.rob_outputs[0]); end
    set_cmpl(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd1) begin fails++; $display("FAIL sq_stale_cmpl: got %0d want 1", bus.rob_outputs_valid); end
  endtask

  task automatic test_retire_clamp();
    do_reset();
    set_dispatch(2, 32'h600);
    tick();
    set_cmpl(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd1) begin fails++; $display("FAIL clamp_ov: got %0d want 1", bus.rob_outputs_valid); end
    bus.num_retiring = 2'd2;
    tick();
    tests++; if (bus.rob_count !== 4'd1) begin fails++; $display("FAIL clamp_count: got %0d want 1", bus.rob_count); end
    tests++; if (bus.rob_outputs[0] !== 32'h601) begin fails++; $display("FAIL clamp_head_out: got %h want 601", bus.rob_outputs[0]); end
    set_cmpl(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tests++; if (bus.rob_outputs_valid !== 2'd1) begin fails++; $display("FAIL clamp_ov_after: got %0d want 1", bus.rob_outputs_valid); end
  endtask

  task automatic test_exception();
    do_reset();
    set_dispatch(2, 32'h700);
    tick();
    set_dispatch(2, 32'h702);
    tick();
    set_cmpl(1'b1, 0, 1'b0, 1'b1, 1, 1'b1);
    tick();
`ifdef ROB_EXCEPTION_EN
    tests++; if (bus.rob_outputs_valid !== 2'd2) begin fails++; $display("FAIL exc_ov: got %0d want 2", bus.rob_outputs_valid); end
    bus.num_retiring = 2'd2;
    tick();
    tests++; if (bus.rob_count !== 4'd0) begin fails++; $display("FAIL exc_count: got %0d want 0", bus.rob_count); end
    tests++; if (bus.rob_flush !== 1'b1) begin fails++; $display("FAIL exc_flush: got %0d want 1", bus.rob_flush); end
    tests++; if (bus.rob_tail !== 3'd2) begin fails++; $display("FAIL exc_tail: got %0d want 2", bus.rob_tail); end
    tick();
    tests++; if (bus.rob_flush !== 1'b0) begin fails++; $display("FAIL exc_flush_pulse: got %0d want 0", bus.rob_flush); end
`else
    tests++; if (bus.rob_outputs_valid !== 2'd2) begin fails++; $display("FAIL noexc_ov: got %0d want 2", bus.rob_outputs_valid); end
    bus.num_retiring = 2'd2;
    tick();
    tests++; if (bus.rob_count !== 4'd2) begin fails++; $display("FAIL noexc_count: got %0d want 2", bus.rob_count); end
    tests++; if (bus.rob_flush !== 1'b0) begin fails++; $display("FAIL noexc_flush: got %0d want 0", bus.rob_flush); end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    idle();
    test_reset();
    test_in_order_retire();
    test_full_and_wrap();
    test_squash();
    test_retire_clamp();
    test_exception();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
